adc_sample_logger: RTL and testbench
====================================

# adc_sample_logger

Avalon-MM write master that captures ADC conversion results from the ADC interface logic and stores them as 32-bit words in the on-chip sample memory, treating that memory as a circular buffer. It sits between the ADC sampling logic and the on-chip memory's Avalon-MM slave port, and is the initiator side of that interface. It exports a write pointer, a wrap flag and a drop counter so software can locate the newest data.

## Interface
Parameters:
- ADDR_W, 18, word-address width; matches the on-chip memory's address port.
- DEPTH, 262144, buffer length in words; must be ≤ 2^ADDR_W; the pointer wraps at DEPTH-1.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  logging enable; when low, new samples are dropped silently, without counting.
- clear  in  1  synchronous one-cycle pulse; resets the pointer, the wrap flag, the drop counter and the timestamp.
- sample_stb  in  1  one-cycle strobe; sample_ch and sample_data are valid while it is high.
- sample_ch  in  4  ADC channel number.
- sample_data  in  12  conversion result, unsigned.
- busy  out  1  high while a word is held or being written; samples that arrive while busy is high are dropped.
- avm_address  out  ADDR_W  word address of the write.
- avm_chipselect  out  1  asserted together with avm_write.
- avm_write  out  1  write request.
- avm_writedata  out  32  packed sample word.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall; tie to 0 for a zero-wait memory.
- wr_ptr  out  ADDR_W  next word address to be written.
- wrapped  out  1  sticky; set on the first wrap from DEPTH-1 to 0.
- drop_cnt  out  16  count of dropped samples; saturates at 16'hFFFF.

## Operation
- Reset values:
  - avm_address, avm_write, avm_chipselect, avm_writedata, wr_ptr, wrapped, drop_cnt, busy, timestamp: all 0.
  - avm_byteenable: 4'hF.
- State machine, two states: IDLE and WRITE.
  - IDLE → WRITE when sample_stb & enable & ~clear. On that edge the block latches the word, sets avm_address = wr_ptr, and asserts avm_write and avm_chipselect.
  - WRITE holds avm_address, avm_writedata, avm_write and avm_chipselect stable while avm_waitrequest is high.
  - WRITE → IDLE on the edge where avm_waitrequest is low. That completes the write; wr_ptr becomes wr_ptr+1, or 0 if wr_ptr = DEPTH-1, which also sets wrapped.
- busy = (state == WRITE).
- Drop: sample_stb & enable while in WRITE increments drop_cnt (saturating). The sample is discarded.
- Word format: {timestamp[15:0], sample_ch[3:0], sample_data[11:0]}. timestamp is a free-running 16-bit cycle counter that wraps modulo 2^16; its value at the accept edge is the one stored.
- clear:
  - In IDLE it takes effect on the next edge. It has priority over a coincident sample_stb; that sample is not written and not counted as dropped.
  - In WRITE, clear is recorded as pending. The bus transaction is never aborted. On completion wr_ptr becomes 0 instead of incrementing; wrapped, drop_cnt and timestamp are zeroed on that same edge.
- enable falling during WRITE: the current write completes normally.
- reset_n asserted mid-transaction: avm_write drops immediately (asynchronous) and all state returns to reset values. A partial write is acceptable.

## Timing
- Accept at edge N → avm_write high during cycle N to N+1.
- With avm_waitrequest = 0: wr_ptr updates at edge N+1 and the FSM is back in IDLE. The next sample is accepted at N+2 at the earliest.
- Maximum throughput is one sample per 2 clk cycles.
- Each waitrequest cycle adds one cycle of latency.
- wr_ptr, wrapped and drop_cnt are registered outputs that change only on clk edges.

## Configuration
- ADC_LOGGER_TIMESTAMP_EN defined: the timestamp counter is built, and writedata[31:16] carries the timestamp.
- Not defined: the counter is not synthesised, and writedata[31:16] = 16'h0000.
- All other behaviour is identical in both builds.

## Test plan
- Write after reset: reset_n low then released; sample_stb with ch=3, data=12'hABC, waitrequest=0. Required: one write to address 0; writedata[15:0] = 16'h3ABC; byteenable 4'hF; wr_ptr = 1.
- Wait states: hold waitrequest high for 3 cycles. Required: address and data stay stable across all 4 cycles with avm_write high; exactly one pointer increment. Strobes during that window raise drop_cnt by 1 each.
- Wrap: DEPTH=4, 5 spaced samples. Required: addresses 0,1,2,3,0; wrapped goes to 1 on the 4th completion; wr_ptr = 1 at the end.
- Clear pending: assert clear during WRITE with waitrequest high. Required: the write completes at its original address, then wr_ptr = 0, wrapped = 0 and drop_cnt = 0.
- Drop saturation: force drop_cnt to 16'hFFFE, then issue 3 strobes while busy. Required: drop_cnt ends at 16'hFFFF.
- Macro build: build without ADC_LOGGER_TIMESTAMP_EN. Required: writedata[31:16] = 0 for every write. Build with it: two samples accepted 10 cycles apart have timestamps that differ by 10.

Source files
------------

// File: rtl/adc_sample_logger.sv
// adc_sample_logger
// Avalon-MM write master that packs ADC conversion results into 32-bit words
// and stores them in on-chip memory used as a circular buffer. Exposes the
// write pointer, a sticky wrap flag and a saturating drop counter.
//
// Build option: ADC_LOGGER_TIMESTAMP_EN
//   defined   - a free-running 16-bit cycle counter is built and stored in
//               writedata[31:16] of every word.
//   undefined - no counter; writedata[31:16] is always 16'h0000.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; a strobe with enable high (and no clear) is taken
// WRITE | word held on the bus until the slave drops avm_waitrequest

module adc_sample_logger #(
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 262144
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_stb,
  input  logic [3:0]        sample_ch,
  input  logic [11:0]       sample_data,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic [15:0]       drop_cnt
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        clear_pend_q;
  logic        accept;
  logic        complete;
  logic        clear_now;
  logic        ptr_last;
  logic [15:0] ts_word;

  // A clear in IDLE acts at once; in WRITE it waits for the bus transfer to
  // finish so a write in flight is never abandoned.
  assign accept    = (state_q == IDLE) & sample_stb & enable & ~clear;
  assign complete  = (state_q == WRITE) & ~avm_waitrequest;
  assign clear_now = ((state_q == IDLE) & clear)
                   | (complete & (clear_pend_q | clear));
  assign ptr_last  = (wr_ptr == ADDR_W'(DEPTH - 1));

`ifdef ADC_LOGGER_TIMESTAMP_EN
  logic [15:0] ts_q;

  // Free-running cycle counter, restarted by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ts_q <= '0;
    else if (clear_now) ts_q <= '0;
    else                ts_q <= ts_q + 16'd1;
  end

  assign ts_word = ts_q;
`else
  assign ts_word = 16'h0000;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = WRITE;
      WRITE:   if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes follow the state directly so reset drops avm_write at once.
  always_comb begin
    busy           = (state_q == WRITE);
    avm_write      = (state_q == WRITE);
    avm_chipselect = (state_q == WRITE);
    avm_byteenable = 4'hF;
  end

  // Latch address and packed word on accept; held stable through wait states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address   <= '0;
      avm_writedata <= '0;
    end else if (accept) begin
      avm_address   <= wr_ptr;
      avm_writedata <= {ts_word, sample_ch, sample_data};
    end
  end

  // Remember a clear seen mid-write until the transfer completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           clear_pend_q <= 1'b0;
    else if (complete)                      clear_pend_q <= 1'b0;
    else if ((state_q == WRITE) && clear)   clear_pend_q <= 1'b1;
  end

  // Circular write pointer and sticky wrap flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
    end else if (clear_now) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
    end else if (complete) begin
      if (ptr_last) begin
        wr_ptr  <= '0;
        wrapped <= 1'b1;
      end else begin
        wr_ptr  <= wr_ptr + 1'b1;
      end
    end
  end

  // Count samples lost while a write is in progress, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt <= '0;
    else if (clear_now)
      drop_cnt <= '0;
    else if ((state_q == WRITE) && sample_stb && enable && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end

endmodule

// File: tb/tb_adc_sample_logger.sv
// Self-checking bench for adc_sample_logger: a transaction-level model
// predicts each accepted word into a queue; a separate monitor compares the
// bus and status outputs against it on the falling edge.

module tb_adc_sample_logger;

  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          clear;
  logic          sample_stb;
  logic [3:0]    sample_ch;
  logic [11:0]   sample_data;
  logic          busy;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest;
  logic [AW-1:0] wr_ptr;
  logic          wrapped;
  logic [15:0]   drop_cnt;

  adc_sample_logger #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .clear           (clear),
    .sample_stb      (sample_stb),
    .sample_ch       (sample_ch),
    .sample_data     (sample_data),
    .busy            (busy),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .wr_ptr          (wr_ptr),
    .wrapped         (wrapped),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer slot index, sticky wrap, drop total, and the
  // timestamp as "edges since the last reset or clear" modulo 2^16.
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        exp_q[$];
  int          m_busy, m_ptr, m_wrapped, m_drops, m_pend;
  int unsigned cyc, base;

  task automatic model_zero(input int unsigned at);
    m_ptr = 0; m_wrapped = 0; m_drops = 0; base = at + 1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_ptr = 0; m_wrapped = 0; m_drops = 0; m_pend = 0;
      cyc = 0; base = 0;
      exp_q.delete();
    end else begin
      if (m_busy == 0) begin
        if (clear) model_zero(cyc);
        else if (sample_stb && enable) begin
          exp_t e;
          logic [15:0] ts;
          ts = 16'(cyc - base);
          e.addr = AW'(m_ptr);
`ifdef ADC_LOGGER_TIMESTAMP_EN
          e.data = {ts, sample_ch, sample_data};
`else
          e.data = {16'h0000, sample_ch, sample_data};
`endif
          exp_q.push_back(e);
          m_busy = 1;
        end
      end else begin
        if (sample_stb && enable && m_drops < 65535) m_drops++;
        if (clear) m_pend = 1;
        if (!avm_waitrequest) begin
          m_busy = 0;
          if (m_pend != 0) begin
            model_zero(cyc);
            m_pend = 0;
          end else begin
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_ptr == 0) m_wrapped = 1;
          end
        end
      end
      cyc++;
    end
  end

  // Monitor: compare outputs with the model and the head of the queue.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", busy, m_busy);
      chk("avm_write", avm_write, m_busy);
      chk("avm_chipselect", avm_chipselect, m_busy);
      chk("wr_ptr", wr_ptr, m_ptr);
      chk("wrapped", wrapped, m_wrapped);
      chk("drop_cnt", drop_cnt, m_drops);
      if (avm_write) begin
        chk("avm_byteenable", avm_byteenable, 4'hF);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("avm_address", avm_address, exp_q[0].addr);
          chk("avm_writedata", avm_writedata, exp_q[0].data);
          if (!avm_waitrequest) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic one_sample(input logic [3:0] ch, input logic [11:0] d);
    sample_stb = 1'b1; sample_ch = ch; sample_data = d;
    tick();
    sample_stb = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; sample_stb = 1'b0;
    sample_ch = '0; sample_data = '0; avm_waitrequest = 1'b0;
    repeat (3) tick();
    chk("rst_address", avm_address, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_chipselect", avm_chipselect, 0);
    chk("rst_writedata", avm_writedata, 0);
    chk("rst_byteenable", avm_byteenable, 4'hF);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // First write after reset.
    one_sample(4'd3, 12'hABC);
    tick();
    chk("first_low_half", avm_writedata[15:0], 16'h3ABC);
    chk("first_wr_ptr", wr_ptr, 1);

    // Three wait states with a strobe in each.
    one_sample(4'd5, 12'h123);
    avm_waitrequest = 1'b1; sample_stb = 1'b1;
    repeat (3) tick();
    avm_waitrequest = 1'b0; sample_stb = 1'b0;
    tick(); tick();
    chk("wait_drop_cnt", drop_cnt, 3);
    chk("wait_wr_ptr", wr_ptr, 2);

    // Wrap: five spaced samples from a cleared pointer.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      one_sample(4'(i), 12'(i * 17));
      tick(); tick();
    end
    chk("wrap_wr_ptr", wr_ptr, 1);
    chk("wrap_flag", wrapped, 1);

    // Clear arriving mid-write is deferred to completion.
    one_sample(4'd9, 12'h5A5);
    avm_waitrequest = 1'b1; sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick();
    avm_waitrequest = 1'b0;
    tick(); tick();
    chk("clrpend_wr_ptr", wr_ptr, 0);
    chk("clrpend_wrapped", wrapped, 0);
    chk("clrpend_drop_cnt", drop_cnt, 0);

    // Timestamps of two samples accepted ten edges apart.
    one_sample(4'd1, 12'h111);
    repeat (9) tick();
    one_sample(4'd2, 12'h222);
    tick(); tick();

    // Drop counter saturation.
    one_sample(4'd7, 12'h777);
    avm_waitrequest = 1'b1; sample_stb = 1'b1;
    repeat (65540) tick();
    avm_waitrequest = 1'b0; sample_stb = 1'b0;
    tick(); tick();
    chk("sat_drop_cnt", drop_cnt, 16'hFFFF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      enable          = ($urandom_range(9) != 0);
      clear           = ($urandom_range(39) == 0);
      sample_stb      = $urandom_range(1);
      sample_ch       = 4'($urandom);
      sample_data     = 12'($urandom);
      avm_waitrequest = ($urandom_range(2) == 0);
      tick();
    end
    enable = 1'b1; clear = 1'b0; sample_stb = 1'b0; avm_waitrequest = 1'b0;
    tick(); tick();

    // Reset in the middle of a stalled write.
    one_sample(4'd4, 12'h444);
    avm_waitrequest = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_write", avm_write, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_ptr", wr_ptr, 0);
    avm_waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    one_sample(4'd6, 12'h666);
    tick(); tick();
    chk("final_wr_ptr", wr_ptr, 1);
    chk("pending_expected", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
